hopfield_controller: RTL and testbench

Sequencing controller for the Hopfield datapath. Accepts LEARN / RECALL / CLEAR commands over a valid/ready interface and drives the datapath's control strobes:
- `modify_neuron`, `modify_neuron_using_input`, `modify_weights` and the datapath reset;
- during recall, iterates the network until `converged` or an iteration limit, then returns the settled `neuron_states` over a valid/ready response.

Sits between the host/test sequencer and `HopfieldDatapath`, replacing hand-sequenced strobes.

---
 rtl/hopfield_pkg.sv | 31 +++
 rtl/hopfield_iter_counter.sv | 33 +++
 rtl/hopfield_controller.sv | 149 ++++++++++++++
 tb/tb_hopfield_controller.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hopfield_pkg.sv
// Shared definitions for the Hopfield sequencing controller: state encoding,
// command opcodes and the pattern width derived from the neuron index range.

`ifndef NEURON_INDEX_MAX
`define NEURON_INDEX_MAX 15
`endif

package hopfield_pkg;

  // Pattern / neuron-state width follows the datapath's neuron index range.
  localparam int N_BITS = `NEURON_INDEX_MAX + 1;

  localparam int LEARN_CYCLES_DEF = 2;
  localparam int MAX_ITER_DEF     = 32;
  localparam int CNT_W            = 6;

  localparam logic [1:0] OP_LEARN    = 2'd0;
  localparam logic [1:0] OP_RECALL   = 2'd1;
  localparam logic [1:0] OP_CLEAR    = 2'd2;
  localparam logic [1:0] OP_RESERVED = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_LEARN = 3'd3,
    S_ITER  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/hopfield_iter_counter.sv
// Phase counter shared by the LEARN hold and the ITER loop. Cleared whenever
// the controller is outside a counted phase, saturates at all-ones, and flags
// the cycle on which the recall loop must give up.

module hopfield_iter_counter
  import hopfield_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] spent,
  output logic             at_limit
);

  // Count completed cycles of the current phase; hold at all-ones.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of earlier cycles, so the current cycle is cnt+1.
  assign spent = (cnt == '1) ? cnt : cnt + 1'b1;

  // The recall loop spends at most MAX_ITER-1 cycles; this is the last one.
  assign at_limit = (({1'b0, cnt} + 7'd2) == 7'(MAX_ITER));

endmodule

// File: rtl/hopfield_controller.sv
// Sequencing controller for the Hopfield datapath. Accepts LEARN / RECALL /
// CLEAR commands and drives the datapath strobes, then returns a response.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender holds valid and payload until then, and the
// controller holds its response payload stable until the same condition.

module hopfield_controller
  import hopfield_pkg::*;
#(
  parameter int LEARN_CYCLES = LEARN_CYCLES_DEF,
  parameter int MAX_ITER     = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [N_BITS-1:0] cmd_pattern,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N_BITS-1:0] rsp_pattern,
  output logic              rsp_converged,
  output logic              rsp_error,
  output logic [CNT_W-1:0]  rsp_iters,
  output logic              dp_rst,
  output logic [N_BITS-1:0] dp_pattern_input,
  output logic              dp_modify_neuron,
  output logic              dp_modify_neuron_using_input,
  output logic              dp_modify_weights,
  input  logic              dp_converged,
  input  logic [N_BITS-1:0] dp_neuron_states,
  output logic [2:0]        dbg_state
);

  state_t           state, state_next;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt, spent;
  logic             at_limit;
  logic             counting;
  logic             accept;
  logic             conv_hit;
  logic             ready_raw, rsp_valid_raw, nm_raw, ui_raw, mw_raw;

  assign counting = (state == S_LEARN) || (state == S_ITER);

  hopfield_iter_counter #(.MAX_ITER(MAX_ITER)) u_cnt (
    .clk      (clk),
    .clr      (rst || !counting),
    .inc      (counting),
    .cnt      (cnt),
    .spent    (spent),
    .at_limit (at_limit)
  );

  // Convergence is only trusted from the third ITER cycle: earlier values may
  // still reflect the pattern load rather than a genuine update.
  assign conv_hit = (cnt >= CNT_W'(2)) && dp_converged;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next    = state;
    ready_raw     = 1'b0;
    rsp_valid_raw = 1'b0;
    nm_raw        = 1'b0;
    ui_raw        = 1'b0;
    mw_raw        = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready_raw = 1'b1;
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_LEARN, OP_RECALL: state_next = S_LOAD;
            OP_CLEAR:            state_next = S_CLEAR;
            default:             state_next = S_RESP;
          endcase
        end
      end
      S_CLEAR: state_next = S_RESP;
      S_LOAD: begin
        nm_raw     = 1'b1;
        ui_raw     = 1'b1;
        state_next = (op_q == OP_LEARN) ? S_LEARN : S_ITER;
      end
      S_LEARN: begin
        mw_raw = 1'b1;
        if (cnt == CNT_W'(LEARN_CYCLES - 1)) state_next = S_RESP;
      end
      S_ITER: begin
        nm_raw = 1'b1;
        if (conv_hit || at_limit) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid_raw = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Everything except the datapath reset is forced low while rst is high.
  assign cmd_ready                    = ready_raw && !rst;
  assign rsp_valid                    = rsp_valid_raw && !rst;
  assign dp_modify_neuron             = nm_raw && !rst;
  assign dp_modify_neuron_using_input = ui_raw && !rst;
  assign dp_modify_weights            = mw_raw && !rst;
  assign dp_rst                       = rst || (state == S_CLEAR);
  assign dbg_state                    = state;
  assign accept                       = cmd_valid && cmd_ready;

  // Command latch and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q             <= OP_LEARN;
      dp_pattern_input <= '0;
      rsp_pattern      <= '0;
      rsp_converged    <= 1'b0;
      rsp_error        <= 1'b0;
      rsp_iters        <= '0;
    end else begin
      if (accept) begin
        op_q             <= cmd_op;
        dp_pattern_input <= cmd_pattern;
        rsp_error        <= (cmd_op == OP_RESERVED);
      end
      if ((state == S_ITER) && (conv_hit || at_limit)) begin
        rsp_pattern   <= dp_neuron_states;
        rsp_converged <= conv_hit;
        rsp_iters     <= spent;
      end
      if ((state == S_RESP) && rsp_ready) begin
        rsp_pattern   <= '0;
        rsp_converged <= 1'b0;
        rsp_error     <= 1'b0;
        rsp_iters     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hopfield_controller.sv
// Bench for hopfield_controller: a behavioural Hopfield datapath driven by the
// controller's strobes, a directed vector table, hand-written reset and
// back-pressure sequences, and randomized commands checked against a
// command-level reference model.

module tb_hopfield_controller;
  import hopfield_pkg::*;

  localparam int LC = 2;
  localparam int MI = 32;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_pattern;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_pattern;
  logic        rsp_converged, rsp_error;
  logic [5:0]  rsp_iters;
  logic        dp_rst;
  logic [15:0] dp_pattern_input;
  logic        dp_modify_neuron, dp_modify_neuron_using_input, dp_modify_weights;
  logic        dp_converged;
  logic [15:0] dp_neuron_states;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  hopfield_controller #(.LEARN_CYCLES(LC), .MAX_ITER(MI)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .cmd_valid                    (cmd_valid),
    .cmd_ready                    (cmd_ready),
    .cmd_op                       (cmd_op),
    .cmd_pattern                  (cmd_pattern),
    .rsp_valid                    (rsp_valid),
    .rsp_ready                    (rsp_ready),
    .rsp_pattern                  (rsp_pattern),
    .rsp_converged                (rsp_converged),
    .rsp_error                    (rsp_error),
    .rsp_iters                    (rsp_iters),
    .dp_rst                       (dp_rst),
    .dp_pattern_input             (dp_pattern_input),
    .dp_modify_neuron             (dp_modify_neuron),
    .dp_modify_neuron_using_input (dp_modify_neuron_using_input),
    .dp_modify_weights            (dp_modify_weights),
    .dp_converged                 (dp_converged),
    .dp_neuron_states             (dp_neuron_states),
    .dbg_state                    (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hopfield arithmetic shared by the datapath model and the reference.
  function automatic int bip(input logic b);
    return b ? 1 : -1;
  endfunction

  function automatic logic [15:0] hop_step(input int w [16][16], input logic [15:0] s);
    logic [15:0] r;
    int acc;
    for (int i = 0; i < 16; i++) begin
      acc = 0;
      for (int j = 0; j < 16; j++) if (j != i) acc += w[i][j] * bip(s[j]);
      r[i] = (acc > 0) ? 1'b1 : (acc < 0) ? 1'b0 : s[i];
    end
    return r;
  endfunction

  // Behavioural datapath: Hebbian learning, synchronous update, change detect.
  int          dpw [16][16];
  logic [15:0] dp_states;
  logic        dp_conv_m;
  bit          force_nc;

  assign dp_converged     = dp_conv_m && !force_nc;
  assign dp_neuron_states = dp_states;

  always @(posedge clk) begin
    if (dp_rst) begin
      for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) dpw[i][j] <= 0;
      dp_states <= '0;
      dp_conv_m <= 1'b0;
    end else begin
      if (dp_modify_weights)
        for (int i = 0; i < 16; i++)
          for (int j = 0; j < 16; j++)
            if (i != j) dpw[i][j] <= dpw[i][j] + bip(dp_pattern_input[i]) * bip(dp_pattern_input[j]);
      if (dp_modify_neuron && dp_modify_neuron_using_input) begin
        dp_states <= dp_pattern_input;
        dp_conv_m <= 1'b0;
      end else if (dp_modify_neuron) begin
        dp_states <= hop_step(dpw, dp_states);
        dp_conv_m <= (hop_step(dpw, dp_states) == dp_states);
      end
    end
  end

  // Command-level reference: weights after each command, recall outcome.
  int ref_w [16][16];

  function automatic void ref_clear();
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) ref_w[i][j] = 0;
  endfunction

  function automatic void ref_learn(input logic [15:0] p);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (i != j) ref_w[i][j] += LC * bip(p[i]) * bip(p[j]);
  endfunction

  // ITER cycle c sees neuron states s(c-1) and a converged flag meaning
  // s(c-1)==s(c-2); the flag counts from cycle 3, the loop ends by cycle MI-1.
  function automatic void ref_recall(input logic [15:0] p, input bit nc,
                                     output logic [15:0] rp, output bit rc, output int iters);
    logic [15:0] cur, prev;
    cur = p;
    prev = p;
    rp = '0;
    rc = 1'b0;
    iters = 0;
    for (int c = 1; c <= MI - 1; c++) begin
      if (c >= 3 && !nc && cur == prev) begin
        rp = cur; rc = 1'b1; iters = c;
        return;
      end
      if (c == MI - 1) begin
        rp = cur; rc = 1'b0; iters = c;
        return;
      end
      prev = cur;
      cur = hop_step(ref_w, cur);
    end
  endfunction

  // Scoreboard compare.
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Driver: issue one command, follow it to its response, release it.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [15:0] pat,
                        input bit nc, input int delay, input logic [15:0] e_pat,
                        input bit e_conv, input bit e_err, input int e_iters);
    int lat, e_lat, n_w, n_load, n_iter, n_rst, n_busy_rdy;
    bit seen, stable;
    logic [15:0] h_pat;
    logic h_conv, h_err;
    logic [5:0] h_iters;
    e_lat = (op == OP_LEARN) ? 2 + LC : (op == OP_CLEAR) ? 2 : (op == OP_RECALL) ? 2 + e_iters : 1;
    force_nc = nc;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1'b1;
    end
    check({tag, "_idle"}, seen, 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_pattern = pat;
    if (delay == 0) rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_pattern = 16'($urandom);
    if (op == OP_LEARN) ref_learn(pat);
    else if (op == OP_CLEAR) ref_clear();
    lat = 0; n_w = 0; n_load = 0; n_iter = 0; n_rst = 0; n_busy_rdy = 0;
    seen = 1'b0;
    for (int n = 1; n <= 80 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) check({tag, "_latch"}, dp_pattern_input, pat);
      if (dp_modify_weights) n_w++;
      if (dp_modify_neuron && dp_modify_neuron_using_input) n_load++;
      if (dp_modify_neuron && !dp_modify_neuron_using_input) n_iter++;
      if (dp_rst) n_rst++;
      if (cmd_ready) n_busy_rdy++;
      if (rsp_valid) begin
        seen = 1'b1;
        lat = n;
      end
    end
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_pattern"}, rsp_pattern, e_pat);
    check({tag, "_converged"}, rsp_converged, e_conv);
    check({tag, "_error"}, rsp_error, e_err);
    check({tag, "_iters"}, rsp_iters, e_iters);
    check({tag, "_weights_cycles"}, n_w, (op == OP_LEARN) ? LC : 0);
    check({tag, "_load_cycles"}, n_load, (op == OP_LEARN || op == OP_RECALL) ? 1 : 0);
    check({tag, "_iter_cycles"}, n_iter, (op == OP_RECALL) ? e_iters : 0);
    check({tag, "_dp_rst_cycles"}, n_rst, (op == OP_CLEAR) ? 1 : 0);
    check({tag, "_busy_ready"}, n_busy_rdy, 0);
    if (!seen) begin
      rsp_ready = 1'b0;
      force_nc = 1'b0;
      return;
    end
    h_pat = rsp_pattern; h_conv = rsp_converged; h_err = rsp_error; h_iters = rsp_iters;
    if (delay > 0) begin
      stable = 1'b1;
      cmd_valid = 1'b1;
      cmd_op = OP_LEARN;
      cmd_pattern = ~pat;
      for (int k = 0; k < delay; k++) begin
        @(negedge clk);
        if (!rsp_valid || cmd_ready || rsp_pattern !== h_pat || rsp_converged !== h_conv ||
            rsp_error !== h_err || rsp_iters !== h_iters)
          stable = 1'b0;
      end
      check({tag, "_hold"}, stable, 1);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_done"}, {rsp_valid, cmd_ready, rsp_converged, rsp_error, rsp_iters, rsp_pattern},
          {1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 16'h0});
    check({tag, "_keep_pattern"}, dp_pattern_input, pat);
    rsp_ready = 1'b0;
    force_nc = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] pat;
    bit          nc;
    int          delay;
    logic [15:0] e_pat;
    bit          e_conv;
    bit          e_err;
    int          e_iters;
  } vec_t;

  vec_t tbl [8];

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

  // Main sequence.
  initial begin
    int r;
    logic [1:0] op;
    logic [15:0] pat, last_learn, e_pat;
    bit nc, e_conv;
    int e_iters;

    tbl[0] = '{OP_CLEAR,    16'h0000, 0, 0, 16'h0000, 0, 0, 0};
    tbl[1] = '{OP_LEARN,    16'hF0F0, 0, 0, 16'h0000, 0, 0, 0};
    tbl[2] = '{OP_RECALL,   16'hF0F1, 0, 5, 16'hF0F0, 1, 0, 3};
    tbl[3] = '{OP_RECALL,   16'h0F0F, 0, 1, 16'h0F0F, 1, 0, 3};
    tbl[4] = '{OP_RECALL,   16'hF0F1, 1, 0, 16'hF0F0, 0, 0, 31};
    tbl[5] = '{OP_RESERVED, 16'hAAAA, 0, 2, 16'h0000, 0, 1, 0};
    tbl[6] = '{OP_CLEAR,    16'h1234, 0, 3, 16'h0000, 0, 0, 0};
    tbl[7] = '{OP_RECALL,   16'hF0F1, 0, 0, 16'hF0F1, 1, 0, 3};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_pattern = '0;
    rsp_ready = 1'b0;
    force_nc = 1'b0;
    ref_clear();
    last_learn = 16'hF0F0;

    // Reset: outputs quiet except the datapath reset.
    @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {cmd_ready, rsp_valid, dp_modify_neuron, dp_modify_neuron_using_input,
                          dp_modify_weights, rsp_converged, rsp_error}, 0);
    check("rst_fields", {rsp_iters, rsp_pattern, dp_pattern_input}, 0);
    check("rst_dp_rst", dp_rst, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_ready", cmd_ready, 1);
    check("release_state", dbg_state, S_IDLE);
    check("release_dp_rst", dp_rst, 0);

    // Directed vectors.
    for (int v = 0; v < 8; v++)
      do_cmd($sformatf("vec%0d", v), tbl[v].op, tbl[v].pat, tbl[v].nc, tbl[v].delay,
             tbl[v].e_pat, tbl[v].e_conv, tbl[v].e_err, tbl[v].e_iters);

    // Reset during ITER: abandon at once and wipe the weights.
    do_cmd("pre_learn", OP_LEARN, 16'hF0F0, 0, 0, 16'h0, 0, 0, 0);
    force_nc = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = OP_RECALL;
    cmd_pattern = 16'hF0F1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_iter_state", dbg_state, S_ITER);
    rst = 1'b1;
    ref_clear();
    @(negedge clk);
    check("mid_rst_outputs", {rsp_valid, dp_modify_neuron, dp_modify_weights, dp_rst}, 4'b0001);
    check("mid_rst_state", dbg_state, S_IDLE);
    rst = 1'b0;
    force_nc = 1'b0;
    #1;
    check("mid_rst_ready", cmd_ready, 1);
    do_cmd("post_rst", OP_RECALL, 16'hF0F1, 0, 1, 16'hF0F1, 1, 0, 3);

    // Randomized commands against the reference model.
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      op = (r <= 2) ? OP_LEARN : (r <= 7) ? OP_RECALL : (r == 8) ? OP_CLEAR : OP_RESERVED;
      pat = 16'($urandom);
      if (op == OP_RECALL && $urandom_range(0, 1) == 1)
        pat = last_learn ^ (16'h0001 << $urandom_range(0, 15));
      if (op == OP_LEARN) last_learn = pat;
      nc = ($urandom_range(0, 7) == 0);
      e_pat = '0;
      e_conv = 1'b0;
      e_iters = 0;
      if (op == OP_RECALL) ref_recall(pat, nc, e_pat, e_conv, e_iters);
      do_cmd($sformatf("rnd%0d", t), op, pat, nc, $urandom_range(0, 3),
             e_pat, e_conv, (op == OP_RESERVED), e_iters);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
